// File: rtl/n_bit_factorial_seq_if.sv
// Start/done handshake bundle for the sequential factorial engine.
// The requester drives Start/Number; the engine returns status and result.
interface n_bit_factorial_seq_if #(
  parameter int N = 4,
  parameter int W = 10 * N
);
  logic         Start;
  logic [N-1:0] Number;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Factorial;
  logic         Overflow;

  modport master (
    output Start,
    output Number,
    input  Busy,
    input  Done,
    input  Factorial,
    input  Overflow
  );

  modport slave (
    input  Start,
    input  Number,
    output Busy,
    output Done,
    output Factorial,
    output Overflow
  );
endinterface

// File: rtl/n_bit_factorial_seq.sv
// Multi-cycle factorial engine: one shared W x N multiply per cycle, counting
// the operand down to 1, with a sticky overflow flag for truncated results.
module n_bit_factorial_seq #(
  parameter int N = 4,
  parameter int W = 10 * N
) (
  input  logic                 clk,
  input  logic                 rst_n,
  n_bit_factorial_seq_if.slave fac
);

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DONE
  } state_t;

  localparam logic [N-1:0] CNT_ONE = N'(1);
  localparam logic [W-1:0] ACC_ONE = W'(1);

  state_t         state_q, state_d;
  logic [N-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   acc_q, acc_d;
  logic           ovf_q, ovf_d;
  logic [W-1:0]   fact_q, fact_d;
  logic           oflow_q, oflow_d;
  logic [W+N-1:0] prod;

  always_comb begin
    prod    = {{N{1'b0}}, acc_q} * {{W{1'b0}}, cnt_q};
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    fact_d  = fact_q;
    oflow_d = oflow_q;
    unique case (state_q)
      IDLE: begin
        if (fac.Start) begin
          cnt_d   = fac.Number;
          acc_d   = ACC_ONE;
          ovf_d   = 1'b0;
          state_d = MULT;
        end
      end
      MULT: begin
        if (cnt_q > CNT_ONE) begin
          acc_d = prod[W-1:0];
          // Any bit spilling above W means the true result no longer fits.
          ovf_d = ovf_q | (|prod[W+N-1:W]);
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          fact_d  = acc_q;
          oflow_d = ovf_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      fact_q  <= '0;
      oflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      fact_q  <= fact_d;
      oflow_q <= oflow_d;
    end
  end

  assign fac.Busy      = (state_q != IDLE);
  assign fac.Done      = (state_q == DONE);
  assign fac.Factorial = fact_q;
  assign fac.Overflow  = oflow_q;

endmodule
